// File: rtl/radix_2_pkg.sv
// radix_2_pkg: shared defaults, mode encodings, Barrett constant and modular add/sub/half helpers (32-bit carriers, WIDTH <= 31)
package radix_2_pkg;
  localparam int WIDTH_DEF = 12;
  localparam int Q_DEF = 3329;
  localparam logic MODE_NTT = 1'b0;
  localparam logic MODE_INTT = 1'b1;
  function automatic logic [63:0] barrett_m(input int w, input int q);
    return (64'd1 << (2 * w)) / 64'(q);
  endfunction
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    logic [31:0] s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction
  function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
    return (a >= b) ? a - b : a + q - b;
  endfunction
  function automatic logic [31:0] mod_half(input logic [31:0] x, input logic [31:0] q);
    return x[0] ? (x + q) >> 1 : x >> 1;
  endfunction
endpackage

// File: rtl/mod_mult_pipe.sv
// mod_mult_pipe: a*b mod Q via Barrett, MULT_STAGES stages (MULT_STAGES-1 product registers gated by en, reduction in the last stage); ports clk, rst, en, a, b -> p
module mod_mult_pipe
  import radix_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q = Q_DEF,
  parameter int MULT_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);
  localparam int W2 = 2 * WIDTH;
  localparam logic [W2-1:0] BM = W2'(barrett_m(WIDTH, Q));
  localparam logic [W2-1:0] QW = W2'(Q);
  localparam logic [WIDTH:0] Q1 = (WIDTH + 1)'(Q);
  logic [W2-1:0] prod, xr, qe;
  logic [WIDTH:0] r1;
  assign prod = W2'(a) * W2'(b);
  if (MULT_STAGES == 1) begin : g_comb
    assign xr = prod;
  end else begin : g_pipe
    logic [W2-1:0] r [MULT_STAGES-1];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r <= '{default: '0};
      end else if (en) begin
        r[0] <= prod;
        for (int i = 1; i < MULT_STAGES - 1; i++) r[i] <= r[i-1];
      end
    assign xr = r[MULT_STAGES-2];
  end
  always_comb begin
    qe = W2'(({{W2{1'b0}}, xr} * {{W2{1'b0}}, BM}) >> W2);
    r1 = (WIDTH + 1)'(xr - qe * QW);
    p = (r1 >= Q1) ? WIDTH'(r1 - Q1) : r1[WIDTH-1:0];
  end
endmodule

// File: rtl/radix_2_pipe.sv
// radix_2_pipe: pipelined CT/GS modular butterfly, LAT=MULT_STAGES+2; in_valid/in_ready/in_a/in_b/in_w/in_mode -> out_valid/out_ready/out_1/out_2/out_mode
module radix_2_pipe
  import radix_2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int Q = Q_DEF,
  parameter int MULT_STAGES = 2,
  parameter int HALVE_INTT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic             out_mode
);
  localparam logic [31:0] Q32 = 32'(Q);
  logic en, v0, m0;
  logic [WIDTH-1:0] a0, b0, w0, x1, w1, s_n, x_n, p, o1_n, o2_n;
  logic [31:0] sum, dif;
  logic [MULT_STAGES-1:0] v_d, m_d;
  logic [WIDTH-1:0] s_d [MULT_STAGES];
  assign en = ~(out_valid & ~out_ready);
  assign in_ready = en;
  always_comb begin
    sum = mod_add(32'(a0), 32'(b0), Q32);
    dif = mod_sub(32'(a0), 32'(b0), Q32);
    s_n = (m0 == MODE_INTT) ? WIDTH'((HALVE_INTT != 0) ? mod_half(sum, Q32) : sum) : a0;
    x_n = (m0 == MODE_INTT) ? WIDTH'((HALVE_INTT != 0) ? mod_half(dif, Q32) : dif) : b0;
    o1_n = (m_d[MULT_STAGES-1] == MODE_INTT) ? s_d[MULT_STAGES-1] : WIDTH'(mod_add(32'(s_d[MULT_STAGES-1]), 32'(p), Q32));
    o2_n = (m_d[MULT_STAGES-1] == MODE_INTT) ? p : WIDTH'(mod_sub(32'(s_d[MULT_STAGES-1]), 32'(p), Q32));
  end
  mod_mult_pipe #(.WIDTH(WIDTH), .Q(Q), .MULT_STAGES(MULT_STAGES)) u_mult (
    .clk(clk),
    .rst(rst),
    .en (en),
    .a  (x1),
    .b  (w1),
    .p  (p)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v0, m0, a0, b0, w0, x1, w1} <= '0;
      v_d <= '0;
      m_d <= '0;
      s_d <= '{default: '0};
      {out_valid, out_mode, out_1, out_2} <= '0;
    end else if (en) begin
      v0 <= in_valid;
      m0 <= in_mode;
      a0 <= in_a;
      b0 <= in_b;
      w0 <= in_w;
      x1 <= x_n;
      w1 <= w0;
      v_d[0] <= v0;
      m_d[0] <= m0;
      s_d[0] <= s_n;
      for (int i = 1; i < MULT_STAGES; i++) begin
        v_d[i] <= v_d[i-1];
        m_d[i] <= m_d[i-1];
        s_d[i] <= s_d[i-1];
      end
      out_valid <= v_d[MULT_STAGES-1];
      out_mode <= m_d[MULT_STAGES-1];
      out_1 <= o1_n;
      out_2 <= o2_n;
    end
endmodule

// File: tb/tb_radix_2_pipe.sv
// tb_radix_2_pipe: directed and random self-checking bench for radix_2_pipe against an arithmetic reference model
module tb_radix_2_pipe;
  localparam int W = 12;
  localparam int Q = 3329;
  localparam int INV2 = (Q + 1) / 2;
  typedef struct packed {
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic m;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_mode = 0, out_ready = 1;
  logic [W-1:0] in_a = 0, in_b = 0, in_w = 0;
  logic in_ready, out_valid, out_mode;
  logic [W-1:0] out_1, out_2;
  exp_t expq[$];
  int checks = 0, errors = 0, ncons = 0, nstall = 0;
  logic acc, held_v = 0;
  logic [W-1:0] h1, h2;
  always #5 clk = ~clk;
  radix_2_pipe #(.WIDTH(W), .Q(Q), .MULT_STAGES(2), .HALVE_INTT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_1(out_1), .out_2(out_2), .out_mode(out_mode)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int a, input int b, input int w, input logic m);
    int t, s, d;
    exp_t e;
    if (!m) begin
      t = (b * w) % Q;
      s = (a + t) % Q;
      d = (a - t + Q) % Q;
    end else begin
      s = ((a + b) % Q) * INV2 % Q;
      d = ((a - b + Q) % Q) * INV2 % Q;
      d = d * w % Q;
    end
    e.o1 = W'(s);
    e.o2 = W'(d);
    e.m = m;
    return e;
  endfunction
  task automatic cyc(input logic v, input int a, input int b, input int w, input logic m, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_a = W'(a);
    in_b = W'(b);
    in_w = W'(w);
    in_mode = m;
    out_ready = ordy;
    #1;
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (held_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_1", out_1, h1);
      chk("hold_2", out_2, h2);
    end
    if (out_valid && out_ready) begin
      if (expq.size() == 0) chk("spurious_out_valid", out_valid, 0);
      else begin
        e = expq.pop_front();
        ncons++;
        chk("out_1", out_1, e.o1);
        chk("out_2", out_2, e.o2);
        chk("out_mode", out_mode, e.m);
      end
    end
    held_v = out_valid && !out_ready;
    if (held_v) nstall++;
    h1 = out_1;
    h2 = out_2;
    acc = in_valid && in_ready;
    if (acc) expq.push_back(model(a, b, w, m));
  endtask
  task automatic one(input int a, input int b, input int w, input logic m, input int e1, input int e2);
    int lat = 0;
    cyc(1, a, b, w, m, 1);
    for (int n = 1; n <= 10; n++) begin
      cyc(0, 0, 0, 0, 0, 1);
      if (out_valid && lat == 0) begin
        lat = n;
        chk("dir_out_1", out_1, e1);
        chk("dir_out_2", out_2, e2);
      end
    end
    chk("latency", lat, 4);
  endtask
  task automatic drain();
    for (int n = 0; n < 50 && expq.size() > 0; n++) cyc(0, 0, 0, 0, 0, 1);
    chk("drain_empty", expq.size(), 0);
  endtask
  initial begin
    int ra, rb, rw, idx, c0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_1", out_1, 0);
    chk("rst_out_2", out_2, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    one(1, 2, 3, 0, 7, 3324);
    one(7, 3324, 1110, 1, 1, 2);
    one(3328, 3328, 3328, 0, 0, 3327);
    one(3328, 3328, 3328, 1, 3328, 0);
    idx = 0;
    c0 = ncons;
    nstall = 0;
    ra = $urandom_range(0, Q - 1);
    rb = $urandom_range(0, Q - 1);
    rw = $urandom_range(0, Q - 1);
    for (int k = 0; k < 40 && (idx < 8 || expq.size() > 0); k++) begin
      cyc(idx < 8, ra, rb, rw, 0, !(k >= 5 && k < 8));
      if (acc) begin
        idx++;
        ra = $urandom_range(0, Q - 1);
        rb = $urandom_range(0, Q - 1);
        rw = $urandom_range(0, Q - 1);
      end
    end
    chk("bp_count", ncons - c0, 8);
    chk("bp_stall_cycles", nstall, 3);
    for (int i = 0; i < 16; i++)
      cyc(1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), $urandom_range(0, Q - 1), (i % 2) == 1, 1);
    drain();
    for (int i = 0; i < 60; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
          $urandom_range(0, Q - 1), $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
    drain();
    cyc(1, 1, 2, 3, 0, 0);
    cyc(1, 4, 5, 6, 1, 0);
    cyc(1, 7, 8, 9, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_out_1", out_1, 7);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out_1", out_1, 0);
    chk("mid_rst_out_2", out_2, 0);
    chk("mid_rst_out_mode", out_mode, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    expq.delete();
    held_v = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 1);
      chk("post_rst_valid", out_valid, 0);
    end
    one(1, 2, 3, 0, 7, 3324);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
